// File: rtl/fixed_order_selector.sv
// Sequencer for the fixed-predictor encoder bank (orders 0-4). It streams one block through
// the encoders, sums absolute residuals per order with warm-up excluded, and picks the cheapest order.
module fixed_order_selector #(
  parameter int ENC_LATENCY = 5,
  parameter int SUM_W       = 32
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    iStart,
  input  logic [15:0]             iBlockSize,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic signed [15:0]      iSample,
  output logic                    oEncEnable,
  output logic                    oEncReset,
  output logic signed [15:0]      oEncSample,
  input  logic signed [15:0]      iResidual0,
  input  logic signed [15:0]      iResidual1,
  input  logic signed [15:0]      iResidual2,
  input  logic signed [15:0]      iResidual3,
  input  logic signed [15:0]      iResidual4,
  output logic [2:0]              oBestOrder,
  output logic [SUM_W-1:0]        oBestSum,
  output logic                    oDone,
  output logic                    oBusy,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_FLUSH   = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [15:0]      block_n;
  logic [15:0]      cnt;      // accepted samples in RUN, cycles in FLUSH, order index in COMPARE
  logic [16:0]      enables;
  logic [16:0]      res_idx;
  logic             acc_en;
  logic [SUM_W-1:0] sums [5];
  logic [SUM_W-1:0] sat_sum [5];
  logic [16:0]      abs_res [5];
  logic [15:0]      res [5];
  logic [SUM_W-1:0] cmp_sum;
  logic [2:0]       best_order;
  logic [SUM_W-1:0] best_sum;

  assign res[0] = iResidual0;
  assign res[1] = iResidual1;
  assign res[2] = iResidual2;
  assign res[3] = iResidual3;
  assign res[4] = iResidual4;

  assign oBestOrder = best_order;
  assign oBestSum   = best_sum;
  assign dbg_state  = state;

  // Sample handshake: a sample transfers on a clock edge where oReady && iValid are both high;
  // iSample must be stable during that cycle. oReady does not depend on iValid.
  always_comb begin
    state_nxt  = state;
    oReady     = 1'b0;
    oEncEnable = 1'b0;
    oEncSample = '0;
    oDone      = 1'b0;
    oBusy      = 1'b0;
    oEncReset  = iReset;
    case (state)
      S_IDLE: if (iStart) state_nxt = S_CLEAR;
      S_CLEAR: begin
        oEncReset = 1'b1;
        oBusy     = 1'b1;
        state_nxt = (block_n == 16'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        oBusy      = 1'b1;
        oReady     = 1'b1;
        oEncEnable = iValid;
        oEncSample = iSample;
        if (iValid && cnt == block_n - 16'd1) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        oBusy      = 1'b1;
        oEncEnable = 1'b1;
        if (cnt == 16'(ENC_LATENCY - 1)) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        oBusy = 1'b1;
        if (cnt == 16'd4) state_nxt = S_DONE;
      end
      S_DONE: begin
        oBusy     = 1'b1;
        oDone     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Reset wins immediately so encoder enable and reset never overlap.
    if (iReset) begin
      oReady     = 1'b0;
      oEncEnable = 1'b0;
      oEncSample = '0;
      oDone      = 1'b0;
      oBusy      = 1'b0;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  assign res_idx = enables - 17'(ENC_LATENCY);
  assign acc_en  = (enables >= 17'(ENC_LATENCY)) && (res_idx < {1'b0, block_n});

  always_comb begin
    cmp_sum = '0;
    for (int k = 0; k < 5; k++) begin
      abs_res[k] = res[k][15] ? (~{1'b1, res[k]} + 17'd1) : {1'b0, res[k]};
      sat_sum[k] = ({1'b0, sums[k]} + {{(SUM_W-16){1'b0}}, abs_res[k]}) > {1'b0, {SUM_W{1'b1}}}
                   ? {SUM_W{1'b1}} : sums[k] + {{(SUM_W-17){1'b0}}, abs_res[k]};
      if (cnt[2:0] == 3'(k)) cmp_sum = sums[k];
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      block_n    <= '0;
      cnt        <= '0;
      enables    <= '0;
      best_order <= '0;
      best_sum   <= '0;
      for (int k = 0; k < 5; k++) sums[k] <= '0;
    end else begin
      if (state_nxt != state)                     cnt <= '0;
      else if (oEncEnable || state == S_COMPARE)  cnt <= cnt + 16'd1;
      if (state == S_IDLE && iStart) block_n <= iBlockSize;
      if (state == S_CLEAR) begin
        enables    <= '0;
        best_order <= '0;
        best_sum   <= '0;
        for (int k = 0; k < 5; k++) sums[k] <= '0;
      end
      if (oEncEnable) begin
        enables <= enables + 17'd1;
        // Residuals with index below the order are warm-up values and never counted.
        if (acc_en)
          for (int k = 0; k < 5; k++)
            if (res_idx >= 17'(k)) sums[k] <= sat_sum[k];
      end
      if (state == S_COMPARE) begin
        if (cnt[2:0] == 3'd0) begin
          best_order <= 3'd0;
          best_sum   <= cmp_sum;
        end else if (block_n > {13'd0, cnt[2:0]} && cmp_sum < best_sum) begin
          best_order <= cnt[2:0];
          best_sum   <= cmp_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_order_selector.sv
// Bench for fixed_order_selector: behavioural encoder bank plus an order-selection model
// derived from k-th differences of the accepted samples.
module tb_fixed_order_selector;
  localparam int LAT   = 5;
  localparam int SUM_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic valid = 1'b0;
  logic [15:0] block_size = '0;
  logic signed [15:0] sample = '0;
  logic ready, enc_en, enc_rst, done, busy;
  logic signed [15:0] enc_sample;
  logic signed [15:0] residual [5] = '{default: '0};
  logic [2:0] best_order, dbg_state;
  logic [SUM_W-1:0] best_sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  int done_seen = 0;
  logic [34:0] exp_q[$];
  int exp_en_q[$];
  int exp_cyc_q[$];

  fixed_order_selector #(.ENC_LATENCY(LAT), .SUM_W(SUM_W)) dut (
    .iClock(clk), .iReset(rst), .iStart(start), .iBlockSize(block_size),
    .iValid(valid), .oReady(ready), .iSample(sample),
    .oEncEnable(enc_en), .oEncReset(enc_rst), .oEncSample(enc_sample),
    .iResidual0(residual[0]), .iResidual1(residual[1]), .iResidual2(residual[2]),
    .iResidual3(residual[3]), .iResidual4(residual[4]),
    .oBestOrder(best_order), .oBestSum(best_sum), .oDone(done), .oBusy(busy),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 100000", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // k-th backward difference at index r, samples before the block treated as zero.
  function automatic longint kth_diff(input int k, input int r, input int xs[$]);
    longint v[5];
    for (int j = 0; j <= k; j++) begin
      int idx = r - k + j;
      v[j] = (idx < 0) ? 0 : longint'(xs[idx]);
    end
    for (int p = 0; p < k; p++)
      for (int j = k; j > p; j--) v[j] = v[j] - v[j-1];
    return v[k];
  endfunction

  function automatic longint model_sum(input int k, input int xs[$]);
    longint s = 0;
    for (int r = k; r < xs.size(); r++) begin
      longint d = kth_diff(k, r, xs);
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  function automatic logic [34:0] model(input int xs[$]);
    int bo = 0;
    longint bs = model_sum(0, xs);
    for (int k = 1; k < 5; k++)
      if (xs.size() > k && model_sum(k, xs) < bs) begin
        bo = k;
        bs = model_sum(k, xs);
      end
    return {3'(bo), 32'(bs)};
  endfunction

  // Behavioural encoder bank: residual r appears during enable cycle r+LAT.
  int hist[$];
  logic cap_en = 1'b0, cap_rst = 1'b1;
  logic signed [15:0] cap_smp = '0;
  always @(negedge clk) begin
    cap_en  = enc_en;
    cap_rst = enc_rst;
    cap_smp = enc_sample;
  end
  always @(posedge clk) begin
    if (cap_rst) hist.delete();
    else if (cap_en) hist.push_back(int'(cap_smp));
    #1;
    for (int k = 0; k < 5; k++)
      residual[k] = (hist.size() >= LAT) ? 16'(kth_diff(k, hist.size() - LAT, hist)) : 16'sd0;
  end

  // Scoreboard / compare process
  always @(negedge clk) begin
    check("enable_reset_exclusive", {63'd0, enc_en & enc_rst}, 64'd0);
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", {63'd0, done}, 64'd0);
      else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        check("best_order", {61'd0, best_order}, {61'd0, e[34:32]});
        check("best_sum", {32'd0, best_sum}, {32'd0, e[31:0]});
        check("enable_count", en_cnt, exp_en_q.pop_front());
        check("done_cycle", cyc, exp_cyc_q.pop_front());
      end
      done_seen++;
    end
    if (enc_rst) en_cnt = 0;
    else if (enc_en) en_cnt++;
  end

  // Driver
  task automatic run_block(input int xs[$], input bit bubbles, input bit mid_start, input bit abort);
    int n = xs.size();
    int i = 0;
    int guard = 0;
    int tog = 0;
    int s_cyc, l_cyc, d0;
    bit acc;
    @(posedge clk); #1;
    start = 1'b1;
    block_size = 16'(n);
    @(negedge clk); s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    block_size = 16'd2;
    if (!abort) begin
      exp_q.push_back(model(xs));
      exp_en_q.push_back(n == 0 ? 0 : n + LAT);
      if (n == 0) exp_cyc_q.push_back(s_cyc + 2);
    end
    l_cyc = 0;
    while (i < n && guard < 200) begin
      valid  = bubbles ? (tog % 2 == 0) : 1'b1;
      tog++;
      sample = 16'(xs[i]);
      start  = mid_start && (i == 2);
      @(negedge clk);
      acc = ready && valid;
      if (acc) l_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) i++;
      guard++;
    end
    valid = 1'b0;
    sample = '0;
    if (i < n) check("samples_accepted", i, n);
    if (abort) begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_enc_reset", {63'd0, enc_rst}, 64'd1);
      check("abort_enc_enable", {63'd0, enc_en}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_idle_state", {61'd0, dbg_state}, 64'd0);
      d0 = done_seen;
      repeat (20) @(negedge clk);
      check("abort_no_done", done_seen - d0, 0);
    end else begin
      if (n > 0) exp_cyc_q.push_back(l_cyc + LAT + 6);
      d0 = done_seen;
      guard = 0;
      while (done_seen == d0 && guard < 60) begin
        @(negedge clk);
        guard++;
      end
      check("done_seen", done_seen - d0, 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_result(input string name, input int order, input longint sum);
    repeat (2) @(negedge clk);
    check({name, "_order"}, {61'd0, best_order}, order);
    check({name, "_sum"}, {32'd0, best_sum}, sum);
    check({name, "_idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int xs[$];
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_enc_reset", {63'd0, enc_rst}, 64'd1);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_enc_enable", {63'd0, enc_en}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_best_order", {61'd0, best_order}, 64'd0);
    check("rst_best_sum", {32'd0, best_sum}, 64'd0);
    check("rst_enc_sample", {48'd0, enc_sample}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_enc_reset", {63'd0, enc_rst}, 64'd0);

    xs = '{100, 100, 100, 100, 100, 100, 100, 100};
    check("model_const_sum0", model_sum(0, xs), 800);
    run_block(xs, 1'b0, 1'b0, 1'b0);
    check_result("const", 1, 0);

    xs.delete();
    for (int i = 0; i < 8; i++) xs.push_back(10 * i);
    check("model_ramp_sum0", model_sum(0, xs), 280);
    check("model_ramp_sum1", model_sum(1, xs), 70);
    check("model_ramp_sum2", model_sum(2, xs), 0);
    run_block(xs, 1'b0, 1'b0, 1'b0);
    check_result("ramp", 2, 0);
    run_block(xs, 1'b1, 1'b0, 1'b0);
    check_result("ramp_bubbles", 2, 0);
    run_block(xs, 1'b0, 1'b1, 1'b0);
    check_result("ramp_mid_start", 2, 0);

    xs = '{5, 5, 5};
    run_block(xs, 1'b0, 1'b0, 1'b0);
    check_result("short", 1, 0);

    xs.delete();
    run_block(xs, 1'b0, 1'b0, 1'b0);
    check_result("empty", 0, 0);

    xs = '{-32768};
    run_block(xs, 1'b0, 1'b0, 1'b0);
    check_result("mag_n1", 0, 32768);

    xs = '{-32768, -32768};
    check("model_mag_sum0", model_sum(0, xs), 65536);
    run_block(xs, 1'b0, 1'b0, 1'b0);
    check_result("mag_n2", 1, 0);

    xs = '{1, -1, 1, -1, 1, -1};
    check("model_alt_sum1", model_sum(1, xs), 10);
    run_block(xs, 1'b0, 1'b0, 1'b0);
    check_result("alternating", 0, 6);

    xs.delete();
    for (int i = 0; i < 8; i++) xs.push_back(10 * i);
    run_block(xs, 1'b0, 1'b0, 1'b1);
    xs = '{100, 100, 100, 100, 100, 100, 100, 100};
    run_block(xs, 1'b0, 1'b0, 1'b0);
    check_result("after_abort", 1, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
